// File: rtl/lfsr_rnd_arbiter.sv
// lfsr_rnd_arbiter: round-robin arbiter handing fresh 5-bit LFSR values to N_REQ requesters
module lfsr_rnd_arbiter #(
  parameter int N_REQ = 4,
  parameter logic [4:0] SEED = 5'b00001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             seed_we_i,
  input  logic [4:0]       seed_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [4:0]       rnd_o,
  output logic             rnd_valid_o,
  output logic             busy_o
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, STEP, GRANT} state_t;
  state_t state_q;
  logic [PW-1:0] ptr_q, sel_q, sel_d, idx;
  logic [4:0] lfsr_q, lfsr_d;
  assign lfsr_d = (lfsr_q == 5'd0) ? 5'b00001 : {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
  assign busy_o = state_q != IDLE;
  // Walk down from the farthest candidate so the nearest set bit after ptr wins.
  always_comb begin
    sel_d = ptr_q;
    idx = ptr_q;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = PW'((int'(ptr_q) + i) % N_REQ);
      sel_d = req_i[idx] ? idx : sel_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      ptr_q       <= PW'(N_REQ - 1);
      sel_q       <= '0;
      gnt_o       <= '0;
      rnd_o       <= '0;
      rnd_valid_o <= 1'b0;
    end else if (seed_we_i) begin
      lfsr_q      <= (seed_i == 5'd0) ? 5'b00001 : seed_i;
      state_q     <= IDLE;
      gnt_o       <= '0;
      rnd_valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req_i) begin
          sel_q   <= sel_d;
          state_q <= STEP;
        end
        STEP: begin
          lfsr_q      <= lfsr_d;
          gnt_o       <= N_REQ'(1) << sel_q;
          rnd_o       <= lfsr_d;
          rnd_valid_o <= 1'b1;
          state_q     <= GRANT;
        end
        GRANT: begin
          gnt_o       <= '0;
          rnd_valid_o <= 1'b0;
          ptr_q       <= sel_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_rnd_arbiter.sv
// tb_lfsr_rnd_arbiter: vector table plus scoreboard checks of grant order and LFSR values
module tb_lfsr_rnd_arbiter;
  logic clk = 1'b0, rst = 1'b1, seed_we = 1'b0;
  logic [3:0] req = '0, gnt;
  logic [4:0] seed = '0, rnd;
  logic rnd_valid, busy;
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] gnt; logic [4:0] rnd;} exp_t;
  typedef struct {logic [3:0] req; logic [3:0] gnt; logic [4:0] rnd;} vec_t;
  exp_t sb[$];
  vec_t tbl[10];
  lfsr_rnd_arbiter #(.N_REQ(4), .SEED(5'b00001)) dut (
    .clk(clk), .rst(rst), .req_i(req), .seed_we_i(seed_we), .seed_i(seed),
    .gnt_o(gnt), .rnd_o(rnd), .rnd_valid_o(rnd_valid), .busy_o(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] lstep(input logic [4:0] v);
    return (v == 5'd0) ? 5'b00001 : {v[3:0], v[4] ^ v[2]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && (gnt != 4'd0 || rnd_valid)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got gnt=%b rnd=%b expected no grant", gnt, rnd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_gnt", 32'(gnt), 32'(e.gnt));
        chk("sb_rnd", 32'(rnd), 32'(e.rnd));
        chk("sb_valid", 32'(rnd_valid), 32'd1);
      end
    end
  end
  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'd0 && n < 20);
    if (gnt == 4'd0) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got no grant expected one within 20 cycles");
      sb.delete();
    end
  endtask
  task automatic do_grant(input logic [3:0] r, input logic [3:0] eg, input logic [4:0] er);
    int n;
    sb.push_back('{eg, er});
    req = r;
    wait_gnt(n);
    req = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    req = '0;
    seed_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    logic [4:0] mq;
    logic [4:0] rec[32];
    logic [31:0] seen;
    int n;
    tbl = '{
      '{4'b0001, 4'b0001, 5'b00010}, '{4'b0001, 4'b0001, 5'b00100},
      '{4'b0001, 4'b0001, 5'b01001}, '{4'b0001, 4'b0001, 5'b10010},
      '{4'b0001, 4'b0001, 5'b00101}, '{4'b1010, 4'b0010, 5'b01011},
      '{4'b1010, 4'b1000, 5'b10110}, '{4'b0110, 4'b0010, 5'b01100},
      '{4'b1001, 4'b1000, 5'b11001}, '{4'b1001, 4'b0001, 5'b10011}};
    do_reset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rnd", 32'(rnd), 0);
    chk("rst_valid", 32'(rnd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    for (int i = 0; i < 10; i++) do_grant(tbl[i].req, tbl[i].gnt, tbl[i].rnd);
    // Continuous all-request: strict rotation, one pulse every 3 cycles.
    do_reset();
    sb.push_back('{4'b0001, 5'b00010});
    sb.push_back('{4'b0010, 5'b00100});
    sb.push_back('{4'b0100, 5'b01001});
    sb.push_back('{4'b1000, 5'b10010});
    sb.push_back('{4'b0001, 5'b00101});
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      if (k > 0) chk("t2_spacing", 32'(n), 3);
    end
    req = '0;
    // Zero seed falls back to 1.
    @(negedge clk);
    seed_we = 1'b1;
    seed = 5'b00000;
    @(negedge clk);
    seed_we = 1'b0;
    chk("t3_busy", 32'(busy), 0);
    do_grant(4'b0001, 4'b0001, 5'b00010);
    // Request dropped after IDLE sampled it is still granted.
    @(negedge clk);
    sb.push_back('{4'b0010, 5'b00100});
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    wait_gnt(n);
    // Seed load during STEP aborts the grant; held request is re-served.
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    chk("t4_busy_step", 32'(busy), 1);
    seed_we = 1'b1;
    seed = 5'b10000;
    @(negedge clk);
    seed_we = 1'b0;
    chk("t4_no_gnt", 32'(gnt), 0);
    chk("t4_no_valid", 32'(rnd_valid), 0);
    chk("t4_idle", 32'(busy), 0);
    chk("t4_rnd_held", 32'(rnd), 32'(5'b00100));
    sb.push_back('{4'b0100, 5'b00001});
    wait_gnt(n);
    req = '0;
    // Full period from SEED.
    do_reset();
    mq = 5'b00001;
    seen = '0;
    for (int i = 0; i < 32; i++) begin
      mq = lstep(mq);
      do_grant(4'b0001, 4'b0001, mq);
      rec[i] = rnd;
    end
    for (int i = 0; i < 31; i++) begin
      chk("t5_nonzero", 32'(rec[i] == 5'd0), 0);
      chk("t5_unique", 32'(seen[rec[i]]), 0);
      seen[rec[i]] = 1'b1;
    end
    chk("t5_wrap", 32'(rec[31]), 32'(rec[0]));
    // Async reset while in GRANT.
    do_reset();
    do_grant(4'b0001, 4'b0001, 5'b00010);
    #2 rst = 1'b1;
    #1;
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_rnd", 32'(rnd), 0);
    chk("t6_valid", 32'(rnd_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    #1 rst = 1'b0;
    do_grant(4'b0001, 4'b0001, 5'b00010);
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
